// File: rtl/mos6502_mbx_pkg.sv
// Shared definitions for the 6502 mailbox responder.
// Contents: register offsets within the 16-byte window, STATUS bit indices
// and IRQ_EN bit indices. There are no ports; other files import this package.
package mos6502_mbx_pkg;

    // Register offsets (cpu_ab[3:0])
    localparam logic [3:0] OFF_DATA    = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h1;
    localparam logic [3:0] OFF_IRQ_EN  = 4'h2;
    localparam logic [3:0] OFF_H2C_CNT = 4'h3;
    localparam logic [3:0] OFF_C2H_CNT = 4'h4;
    localparam logic [3:0] OFF_SCRATCH = 4'h5;

    // STATUS bit positions
    localparam int ST_H2C_NE   = 0;
    localparam int ST_C2H_FULL = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_UNF      = 3;
    localparam int ST_IRQ      = 4;

    // IRQ_EN bit positions
    localparam int IE_H2C_NE    = 0;
    localparam int IE_C2H_EMPTY = 1;

endpackage

// File: rtl/mbx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used for both mailbox directions.
// Ports:
//   wb_clk_i, rst_n   clock and synchronous active-low reset (flushes contents)
//   push, din         write request and data
//   pop, dout         read request; dout is the current head, valid while !empty
//   full, empty       occupancy flags
//   count             occupancy 0..DEPTH
// A push while full is accepted only if a pop happens on the same edge.
// A pop while empty is ignored.
module mbx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_reg;
    // Fall-through head: combinational read of the entry at the read pointer
    assign dout    = mem[rd_ptr_reg];

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mos6502_mailbox_responder.sv
// 6502 bus responder: 16-byte register window with registered read data,
// two byte FIFOs (host->CPU and CPU->host), sticky OVF/UNF flags and a
// level-sensitive active-low IRQ.
// Ports:
//   wb_clk_i, rst_n                 clock, synchronous active-low reset
//   cpu_ab, cpu_do, cpu_we          6502 address, write data, write enable
//   cpu_di, hit_o                   registered read data and read-hit flag
//   irq_n                           registered interrupt request, active low
//   h2c_data/h2c_valid/h2c_ready    host -> CPU byte stream
//   c2h_data/c2h_valid/c2h_ready    CPU -> host byte stream (FIFO head)
module mos6502_mailbox_responder
    import mos6502_mbx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hD000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        hit_o,
    output logic        irq_n,
    input  logic [7:0]  h2c_data,
    input  logic        h2c_valid,
    output logic        h2c_ready,
    output logic [7:0]  c2h_data,
    output logic        c2h_valid,
    input  logic        c2h_ready
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       off;
    logic             sel, rd, wr;
    logic             rd_data, wr_data;
    logic             h2c_push, h2c_pop, c2h_push, c2h_pop;
    logic             h2c_full, h2c_empty, c2h_full, c2h_empty;
    logic [7:0]       h2c_head;
    logic [CNT_W-1:0] h2c_count, c2h_count;
    logic             ovf_set, unf_set;
    logic             irq_cond;
    logic [7:0]       rdata;
    logic             ovf_next, unf_next;

    logic [7:0]       cpu_di_reg;
    logic             hit_reg;
    logic             irq_n_reg;
    logic             ovf_reg, unf_reg;
    logic [1:0]       irq_en_reg;
    logic [7:0]       scratch_reg;
    logic             ready_en_reg;

    assign sel     = (cpu_ab[15:4] == BASE_ADDR[15:4]);
    assign off     = cpu_ab[3:0];
    assign rd      = sel & ~cpu_we;
    assign wr      = sel & cpu_we;
    assign rd_data = rd & (off == OFF_DATA);
    assign wr_data = wr & (off == OFF_DATA);

    // ready_en_reg holds h2c_ready low through reset and the release edge
    assign h2c_ready = ready_en_reg & ~h2c_full;
    assign h2c_push  = h2c_valid & h2c_ready;
    // Every DATA read cycle pops, dummy reads included
    assign h2c_pop   = rd_data & ~h2c_empty;
    assign unf_set   = rd_data & h2c_empty;

    assign c2h_valid = ~c2h_empty;
    assign c2h_pop   = c2h_valid & c2h_ready;
    // A full C2H still takes a CPU byte if the host frees a slot on the same edge
    assign c2h_push  = wr_data & (~c2h_full | c2h_pop);
    assign ovf_set   = wr_data & c2h_full & ~c2h_pop;

    assign irq_cond = (irq_en_reg[IE_H2C_NE] & ~h2c_empty) |
                      (irq_en_reg[IE_C2H_EMPTY] & c2h_empty);

    mbx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_h2c_fifo (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .push     (h2c_push),
        .pop      (h2c_pop),
        .din      (h2c_data),
        .dout     (h2c_head),
        .full     (h2c_full),
        .empty    (h2c_empty),
        .count    (h2c_count)
    );

    mbx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_c2h_fifo (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .push     (c2h_push),
        .pop      (c2h_pop),
        .din      (cpu_do),
        .dout     (c2h_data),
        .full     (c2h_full),
        .empty    (c2h_empty),
        .count    (c2h_count)
    );

    // Read mux, evaluated on pre-edge state
    always_comb begin
        rdata = 8'h00;
        case (off)
            OFF_DATA:    rdata = h2c_empty ? 8'h00 : h2c_head;
            OFF_STATUS:  rdata = {3'b000, irq_cond, unf_reg, ovf_reg, c2h_full, ~h2c_empty};
            OFF_IRQ_EN:  rdata = {6'b000000, irq_en_reg};
            OFF_H2C_CNT: rdata = 8'(h2c_count);
            OFF_C2H_CNT: rdata = 8'(c2h_count);
            OFF_SCRATCH: rdata = scratch_reg;
            default:     rdata = 8'h00;
        endcase
    end

    // Sticky flags: W1C first, a set on the same edge overrides it
    always_comb begin
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        if (wr && off == OFF_STATUS) begin
            if (cpu_do[ST_OVF]) ovf_next = 1'b0;
            if (cpu_do[ST_UNF]) unf_next = 1'b0;
        end
        if (ovf_set) ovf_next = 1'b1;
        if (unf_set) unf_next = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            cpu_di_reg   <= 8'h00;
            hit_reg      <= 1'b0;
            irq_n_reg    <= 1'b1;
            ovf_reg      <= 1'b0;
            unf_reg      <= 1'b0;
            irq_en_reg   <= 2'b00;
            scratch_reg  <= 8'h00;
            ready_en_reg <= 1'b0;
        end else begin
            cpu_di_reg   <= rd ? rdata : 8'h00;
            hit_reg      <= rd;
            irq_n_reg    <= ~irq_cond;
            ovf_reg      <= ovf_next;
            unf_reg      <= unf_next;
            ready_en_reg <= 1'b1;
            if (wr && off == OFF_IRQ_EN)  irq_en_reg  <= cpu_do[1:0];
            if (wr && off == OFF_SCRATCH) scratch_reg <= cpu_do;
        end
    end

    assign cpu_di = cpu_di_reg;
    assign hit_o  = hit_reg;
    assign irq_n  = irq_n_reg;

endmodule

// File: tb/tb_mos6502_mailbox_responder.sv
// Directed testbench for mos6502_mailbox_responder (BASE_ADDR=D000, depth 8).
module tb_mos6502_mailbox_responder;

    logic        wb_clk_i = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        hit_o;
    logic        irq_n;
    logic [7:0]  h2c_data;
    logic        h2c_valid;
    logic        h2c_ready;
    logic [7:0]  c2h_data;
    logic        c2h_valid;
    logic        c2h_ready;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    mos6502_mailbox_responder #(.BASE_ADDR(16'hD000), .FIFO_DEPTH(8)) dut (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .cpu_ab    (cpu_ab),
        .cpu_do    (cpu_do),
        .cpu_we    (cpu_we),
        .cpu_di    (cpu_di),
        .hit_o     (hit_o),
        .irq_n     (irq_n),
        .h2c_data  (h2c_data),
        .h2c_valid (h2c_valid),
        .h2c_ready (h2c_ready),
        .c2h_data  (c2h_data),
        .c2h_valid (c2h_valid),
        .c2h_ready (c2h_ready)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One clock, then settle 1 ns past the edge before sampling/driving
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp_di,
                            input logic exp_hit, input string tag);
        cpu_ab = addr;
        cpu_we = 1'b0;
        tick();
        check({tag, " di"}, {8'h00, cpu_di}, {8'h00, exp_di});
        check({tag, " hit"}, {15'h0, hit_o}, {15'h0, exp_hit});
        cpu_ab = 16'h0000;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        cpu_ab = addr;
        cpu_do = data;
        cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        cpu_ab = 16'h0000;
    endtask

    task automatic host_push(input logic [7:0] data);
        h2c_data  = data;
        h2c_valid = 1'b1;
        tick();
        h2c_valid = 1'b0;
    endtask

    task automatic host_pop(input logic [7:0] exp, input string tag);
        check({tag, " valid"}, {15'h0, c2h_valid}, 16'h0001);
        check({tag, " data"}, {8'h00, c2h_data}, {8'h00, exp});
        c2h_ready = 1'b1;
        tick();
        c2h_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cpu_ab = 16'h0000; cpu_do = 8'h00; cpu_we = 1'b0;
        h2c_data = 8'h00; h2c_valid = 1'b0; c2h_ready = 1'b0;

        // 1. Reset
        repeat (3) tick();
        check("rst irq_n", {15'h0, irq_n}, 16'h0001);
        check("rst cpu_di", {8'h0, cpu_di}, 16'h0000);
        check("rst hit", {15'h0, hit_o}, 16'h0000);
        check("rst h2c_ready", {15'h0, h2c_ready}, 16'h0000);
        check("rst c2h_valid", {15'h0, c2h_valid}, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("post-rst h2c_ready", {15'h0, h2c_ready}, 16'h0001);
        bus_read(16'hD001, 8'h00, 1'b1, "rst STATUS");
        bus_read(16'hD003, 8'h00, 1'b1, "rst H2C_CNT");
        bus_read(16'hD004, 8'h00, 1'b1, "rst C2H_CNT");

        // 2. Host->CPU path and underflow
        host_push(8'h11);
        host_push(8'h22);
        bus_read(16'hD003, 8'h02, 1'b1, "H2C_CNT=2");
        bus_read(16'hD000, 8'h11, 1'b1, "DATA 1st");
        bus_read(16'hD000, 8'h22, 1'b1, "DATA 2nd");
        bus_read(16'hD000, 8'h00, 1'b1, "DATA empty");
        bus_read(16'hD001, 8'h08, 1'b1, "STATUS UNF");
        bus_write(16'hD001, 8'h08);
        bus_read(16'hD001, 8'h00, 1'b1, "STATUS cleared");

        // 3. CPU->host overflow and ordered drain
        for (int i = 1; i <= 9; i++) bus_write(16'hD000, 8'(i));
        bus_read(16'hD004, 8'h08, 1'b1, "C2H_CNT full");
        bus_read(16'hD001, 8'h06, 1'b1, "STATUS full+OVF");
        for (int i = 1; i <= 8; i++) host_pop(8'(i), $sformatf("drain %0d", i));
        check("drained valid", {15'h0, c2h_valid}, 16'h0000);
        bus_write(16'hD001, 8'h04);
        bus_read(16'hD001, 8'h00, 1'b1, "OVF cleared");

        // 4. IRQ on H2C not empty
        bus_write(16'hD002, 8'h01);
        check("irq idle", {15'h0, irq_n}, 16'h0001);
        host_push(8'hAA);
        check("irq +1", {15'h0, irq_n}, 16'h0001);
        tick();
        check("irq +2", {15'h0, irq_n}, 16'h0000);
        bus_read(16'hD000, 8'hAA, 1'b1, "irq DATA");
        check("irq at pop", {15'h0, irq_n}, 16'h0000);
        tick();
        check("irq after pop", {15'h0, irq_n}, 16'h0001);
        // IRQ on C2H empty
        bus_write(16'hD002, 8'h02);
        tick();
        check("irq c2h empty", {15'h0, irq_n}, 16'h0000);
        bus_read(16'hD002, 8'h02, 1'b1, "IRQ_EN rb");
        bus_read(16'hD001, 8'h10, 1'b1, "STATUS irq");
        bus_write(16'hD002, 8'h00);
        tick();
        check("irq off", {15'h0, irq_n}, 16'h0001);

        // 5. Full C2H with simultaneous CPU write and host pop
        for (int i = 0; i < 8; i++) bus_write(16'hD000, 8'hB0 + 8'(i));
        cpu_ab = 16'hD000; cpu_do = 8'h5A; cpu_we = 1'b1; c2h_ready = 1'b1;
        tick();
        cpu_we = 1'b0; cpu_ab = 16'h0000; c2h_ready = 1'b0;
        bus_read(16'hD004, 8'h08, 1'b1, "simul C2H_CNT");
        bus_read(16'hD001, 8'h02, 1'b1, "simul no OVF");
        for (int i = 1; i < 8; i++) host_pop(8'hB0 + 8'(i), $sformatf("simul drain %0d", i));
        host_pop(8'h5A, "simul last");

        // 6. Decode, scratch and reset mid-transfer
        bus_write(16'hD005, 8'h77);
        bus_read(16'hD005, 8'h77, 1'b1, "SCRATCH");
        bus_read(16'hD010, 8'h00, 1'b0, "miss D010");
        bus_read(16'hCFFF, 8'h00, 1'b0, "miss CFFF");
        bus_read(16'hD00F, 8'h00, 1'b1, "unused D00F");
        host_push(8'h01); host_push(8'h02); host_push(8'h03);
        bus_write(16'hD000, 8'hC1); bus_write(16'hD000, 8'hC2); bus_write(16'hD000, 8'hC3);
        bus_read(16'hD003, 8'h03, 1'b1, "queued H2C");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(16'hD003, 8'h00, 1'b1, "after rst H2C_CNT");
        bus_read(16'hD004, 8'h00, 1'b1, "after rst C2H_CNT");
        bus_read(16'hD005, 8'h00, 1'b1, "after rst SCRATCH");
        check("after rst c2h_valid", {15'h0, c2h_valid}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mos6502_mailbox_responder.md
Name: mos6502_mailbox_responder

Overview:
Bus responder on the 6502 external bus (AB/DO/WE in, DI out).
- Decodes a 16-byte register window and returns registered read data with synchronous-memory timing, so the core's data input can take it directly.
- Provides two byte FIFOs between the CPU and a host-side stream interface, sticky error flags, and a level-sensitive active-low IRQ.
- Sits beside the 6502 wrapper at top level. The top muxes cpu_di onto the core's data input when hit_o is set.

Parameters:
BASE_ADDR, 16'hD000, window base; bits [3:0] must be 0; window = BASE_ADDR..BASE_ADDR+15.
FIFO_DEPTH, 8, entries per FIFO; power of 2, >=2, <=128.

Ports:
wb_clk_i  in  1  clock
rst_n  in  1  synchronous, active-low reset
cpu_ab  in  16  CPU address bus
cpu_do  in  8  CPU write data
cpu_we  in  1  CPU write enable, 1 = write
cpu_di  out  8  read data to CPU, registered
hit_o  out  1  registered: previous-cycle address hit the window
irq_n  out  1  registered interrupt request, active low
h2c_data  in  8  host-to-CPU byte
h2c_valid  in  1  host byte valid
h2c_ready  out  1  H2C FIFO not full
c2h_data  out  8  CPU-to-host byte (C2H FIFO head)
c2h_valid  out  1  C2H FIFO not empty
c2h_ready  in  1  host accepts c2h_data

Behaviour:
Reset and clocking
- Reset rst_n, synchronous, active-low; clock wb_clk_i.
- All state updates on the rising edge of wb_clk_i.
- While rst_n=0: both FIFOs flushed, all registers 0, cpu_di=0, hit_o=0, irq_n=1, h2c_ready=0, c2h_valid=0.
- h2c_ready goes to 1 on the first cycle after reset release.

Bus decode and read timing
- sel = (cpu_ab[15:4] == BASE_ADDR[15:4]); off = cpu_ab[3:0].
- Sampled each edge: cpu_di <= sel&~cpu_we ? rdata(off) : 8'h00; hit_o <= sel&~cpu_we.
- Read latency is 1 cycle.
- Writes take effect on the same edge.

Register map (by off)
- 0x0 DATA
  - Write: push cpu_do to C2H. If C2H is full, drop the byte and set OVF.
  - Read: return the H2C head and pop it. If H2C is empty, return 0x00 and set UNF.
  - Every read bus cycle pops, including 6502 dummy reads.
- 0x1 STATUS
  - Read bits: [0] H2C not empty, [1] C2H full, [2] OVF, [3] UNF, [4] irq active, [7:5] 0.
  - Write: write-1-to-clear on bits [2] and [3]; other bits ignored.
- 0x2 IRQ_EN, r/w, bits [1:0]; upper bits read 0.
- 0x3 H2C_CNT, read-only, occupancy 0..FIFO_DEPTH.
- 0x4 C2H_CNT, read-only, occupancy 0..FIFO_DEPTH.
- 0x5 SCRATCH, r/w, 8 bits.
- 0x6..0xF: read 0x00, writes ignored.

Host stream side
- H2C push when h2c_valid & h2c_ready.
- C2H pop when c2h_valid & c2h_ready.
- c2h_data is the combinational FIFO head.

Interrupt
- irq_n <= ~((IRQ_EN[0] & H2C not empty) | (IRQ_EN[1] & C2H empty)).
- Level-sensitive; follows conditions with 1-cycle lag.

Boundaries
- FIFO push and pop in the same cycle: both occur, count unchanged. On a full FIFO, push is legal only with a simultaneous pop for C2H (CPU write plus host pop); H2C relies on h2c_ready being low.
- A CPU read of DATA returns the pre-edge head; a host push in the same cycle into an empty H2C is not returned.
- A sticky-flag set and a W1C on the same edge: set wins.
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-transfer discards all FIFO contents and flags.

Decomposition:
- Package mos6502_mbx_pkg holds:
  - register offset localparams (OFF_DATA..OFF_SCRATCH);
  - STATUS bit indices;
  - IRQ_EN bit indices.
- One sub-module, mbx_sync_fifo (params WIDTH, DEPTH), instantiated twice.
  - Ports: push, pop, din, dout, full, empty, count.
  - Synchronous reset, first-word fall-through.

Test Plan:
1. Reset: after rst_n=0 then 1 -> irq_n=1, cpu_di=0x00, hit_o=0; next cycle h2c_ready=1; reads of 0x1, 0x3, 0x4 return 0x00.
2. Host pushes 0x11, 0x22; CPU reads 0xD000 twice -> cpu_di=0x11 then 0x22 (1-cycle latency, hit_o=1); third read -> 0x00 and STATUS=0x08; writing 0x08 to 0xD001 clears STATUS to 0x00.
3. CPU writes 9 bytes 0x01..0x09 to 0xD000 with c2h_ready=0, DEPTH=8 -> C2H_CNT=8, STATUS=0x06; host drains 0x01..0x08 in order.
4. Write 0x01 to 0xD002 -> irq_n=1; host push 0xAA -> irq_n=0 two cycles later; CPU reads 0xD000 -> irq_n=1 one cycle after the pop.
5. Simultaneous: C2H full, CPU write 0x5A and host pop on the same edge -> no OVF, C2H_CNT stays 8, 0x5A is last out.
6. Decode: write 0x77 to 0xD005, read back 0x77; read 0xD010 and 0xCFFF -> hit_o=0, cpu_di=0x00; assert rst_n=0 with 3 bytes queued -> counts 0 after reset.
